// File: rtl/branch_flag_unit_if.sv
// Bus between the ALU/zero-detect/issue side and the branch flag unit.
// The master drives flag writes and branch requests. The slave returns the resolved fetch controls.
interface branch_flag_unit_if #(
  parameter int AW = 8
);
  logic          flag_we;
  logic          zero_in;
  logic          carry_in;
  logic          neg_in;
  logic          br_valid;
  logic [2:0]    br_cond;
  logic [AW-1:0] br_target;
  logic          br_ready;
  logic [2:0]    flags_q;
  logic          pc_load;
  logic [AW-1:0] pc_target;
  logic          flush;
  logic          cond_err;
  logic [7:0]    taken_cnt;

  modport master (
    output flag_we, zero_in, carry_in, neg_in, br_valid, br_cond, br_target,
    input  br_ready, flags_q, pc_load, pc_target, flush, cond_err, taken_cnt
  );

  modport slave (
    input  flag_we, zero_in, carry_in, neg_in, br_valid, br_cond, br_target,
    output br_ready, flags_q, pc_load, pc_target, flush, cond_err, taken_cnt
  );
endinterface

// File: rtl/branch_flag_unit.sv
// Holds the {N,C,Z} status register and resolves conditional branches against it.
// A taken branch drives a one-cycle PC load and then a fixed-length pipeline flush.
module branch_flag_unit #(
  parameter int AW           = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_flag_unit_if.slave  bus
);

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  typedef enum logic [2:0] {
    C_ALWAYS = 3'b000,
    C_Z      = 3'b001,
    C_NZ     = 3'b010,
    C_C      = 3'b011,
    C_NC     = 3'b100,
    C_N      = 3'b101,
    C_NN     = 3'b110,
    C_RSVD   = 3'b111
  } cond_e;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e        state_q, state_d;
  logic [3:0]    fcnt_q, fcnt_d;
  logic [2:0]    flag_q, flag_d;
  logic          pc_load_q, pc_load_d;
  logic [AW-1:0] pc_target_q, pc_target_d;
  logic          cond_err_q, cond_err_d;
  logic [7:0]    taken_q, taken_d;

  logic          ready;
  logic          accept;
  logic          cond_true;
  logic          take;
  logic [2:0]    eff_flags;

  assign accept = bus.br_valid & ready;
  assign take   = accept & cond_true;

  // Incoming flags win over the stored ones when both are written in the same cycle.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    eff_flags = bus.flag_we ? {bus.neg_in, bus.carry_in, bus.zero_in} : flag_q;
    cond_true = 1'b0;
    case (cond_e'(bus.br_cond))
      C_ALWAYS: cond_true = 1'b1;
      C_Z:      cond_true = eff_flags[0];
      C_NZ:     cond_true = ~eff_flags[0];
      C_C:      cond_true = eff_flags[1];
      C_NC:     cond_true = ~eff_flags[1];
      C_N:      cond_true = eff_flags[2];
      C_NN:     cond_true = ~eff_flags[2];
      default:  cond_true = 1'b0;
    endcase
  end

  // NOTE: sequential state is assigned with non-blocking (<=) only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // The flush counter is loaded on entry and covers the pc_load cycle as the first flush cycle.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_FLUSH;
          fcnt_d  = FLUSH_LAST;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == 4'd0) state_d = S_IDLE;
        else                fcnt_d  = fcnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == S_IDLE);
    bus.flush = (state_q == S_FLUSH);
  end

  always_comb begin
    flag_d      = bus.flag_we ? {bus.neg_in, bus.carry_in, bus.zero_in} : flag_q;
    pc_load_d   = take;
    pc_target_d = take ? bus.br_target : pc_target_q;
    cond_err_d  = accept && (bus.br_cond == C_RSVD);
    taken_d     = (take && taken_q != 8'hFF) ? taken_q + 8'd1 : taken_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q      <= '0;
      pc_load_q   <= 1'b0;
      pc_target_q <= '0;
      cond_err_q  <= 1'b0;
      taken_q     <= '0;
    end else begin
      flag_q      <= flag_d;
      pc_load_q   <= pc_load_d;
      pc_target_q <= pc_target_d;
      cond_err_q  <= cond_err_d;
      taken_q     <= taken_d;
    end
  end

  assign bus.br_ready  = ready;
  assign bus.flags_q   = flag_q;
  assign bus.pc_load   = pc_load_q;
  assign bus.pc_target = pc_target_q;
  assign bus.cond_err  = cond_err_q;
  assign bus.taken_cnt = taken_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit: a per-cycle vector table plus hand-written reset and saturation sequences.
module tb_branch_flag_unit;

  localparam int AW = 8;

  typedef struct {
    logic       we, z, c, n, v;
    logic [2:0] cond;
    logic [7:0] tgt;
    logic       rdy;
    logic [2:0] flags;
    logic       pl;
    logic [7:0] pt;
    logic       fl;
    logic       ce;
    logic [7:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  branch_flag_unit_if #(.AW(AW)) bf_if ();

  branch_flag_unit #(.AW(AW), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bf_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, z, c, n, v, input logic [2:0] cond,
                              input logic [7:0] tgt, input logic rdy, input logic [2:0] flags,
                              input logic pl, input logic [7:0] pt, input logic fl,
                              input logic ce, input logic [7:0] cnt);
    vec_t r;
    r.we = we; r.z = z; r.c = c; r.n = n; r.v = v; r.cond = cond; r.tgt = tgt;
    r.rdy = rdy; r.flags = flags; r.pl = pl; r.pt = pt; r.fl = fl; r.ce = ce; r.cnt = cnt;
    return r;
  endfunction

  task automatic drive(input logic we, z, c, n, v, input logic [2:0] cond, input logic [7:0] tgt);
    bf_if.flag_we   = we;
    bf_if.zero_in   = z;
    bf_if.carry_in  = c;
    bf_if.neg_in    = n;
    bf_if.br_valid  = v;
    bf_if.br_cond   = cond;
    bf_if.br_target = tgt;
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic [2:0] flags,
                            input logic pl, input logic [7:0] pt, input logic fl,
                            input logic ce, input logic [7:0] cnt);
    check({tag, ".br_ready"},  int'(bf_if.br_ready),  int'(rdy));
    check({tag, ".flags_q"},   int'(bf_if.flags_q),   int'(flags));
    check({tag, ".pc_load"},   int'(bf_if.pc_load),   int'(pl));
    check({tag, ".pc_target"}, int'(bf_if.pc_target), int'(pt));
    check({tag, ".flush"},     int'(bf_if.flush),     int'(fl));
    check({tag, ".cond_err"},  int'(bf_if.cond_err),  int'(ce));
    check({tag, ".taken_cnt"}, int'(bf_if.taken_cnt), int'(cnt));
  endtask

  // Each row: inputs applied in this cycle, and outputs expected in this same cycle (before its rising edge).
  vec_t tbl[22];

  initial begin
    //            we z  c  n  v  cond    tgt    | rdy flags   pl pt     fl ce cnt
    tbl[0]  = mk(1, 1, 0, 1, 0, 3'd0, 8'h00,   1, 3'b000, 0, 8'h00, 0, 0, 8'd0);
    tbl[1]  = mk(0, 0, 0, 0, 1, 3'd1, 8'h3C,   1, 3'b101, 0, 8'h00, 0, 0, 8'd0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 3'd0, 8'h00,   0, 3'b101, 1, 8'h3C, 1, 0, 8'd1);
    tbl[3]  = mk(0, 0, 0, 0, 1, 3'd0, 8'h55,   0, 3'b101, 0, 8'h3C, 1, 0, 8'd1);
    tbl[4]  = mk(0, 0, 0, 0, 1, 3'd0, 8'h55,   1, 3'b101, 0, 8'h3C, 0, 0, 8'd1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 3'd0, 8'h00,   0, 3'b101, 1, 8'h55, 1, 0, 8'd2);
    tbl[6]  = mk(0, 0, 0, 0, 0, 3'd0, 8'h00,   0, 3'b101, 0, 8'h55, 1, 0, 8'd2);
    tbl[7]  = mk(0, 0, 0, 0, 1, 3'd2, 8'h77,   1, 3'b101, 0, 8'h55, 0, 0, 8'd2);
    tbl[8]  = mk(0, 0, 0, 0, 1, 3'd7, 8'h88,   1, 3'b101, 0, 8'h55, 0, 0, 8'd2);
    tbl[9]  = mk(1, 0, 1, 0, 0, 3'd0, 8'h00,   1, 3'b101, 0, 8'h55, 0, 1, 8'd2);
    tbl[10] = mk(1, 1, 1, 0, 1, 3'd1, 8'h9A,   1, 3'b010, 0, 8'h55, 0, 0, 8'd2);
    tbl[11] = mk(0, 0, 0, 0, 0, 3'd0, 8'h00,   0, 3'b011, 1, 8'h9A, 1, 0, 8'd3);
    tbl[12] = mk(0, 0, 0, 0, 0, 3'd0, 8'h00,   0, 3'b011, 0, 8'h9A, 1, 0, 8'd3);
    tbl[13] = mk(0, 0, 0, 0, 1, 3'd4, 8'h11,   1, 3'b011, 0, 8'h9A, 0, 0, 8'd3);
    tbl[14] = mk(0, 0, 0, 0, 1, 3'd3, 8'h22,   1, 3'b011, 0, 8'h9A, 0, 0, 8'd3);
    tbl[15] = mk(0, 0, 0, 0, 0, 3'd0, 8'h00,   0, 3'b011, 1, 8'h22, 1, 0, 8'd4);
    tbl[16] = mk(0, 0, 0, 0, 0, 3'd0, 8'h00,   0, 3'b011, 0, 8'h22, 1, 0, 8'd4);
    tbl[17] = mk(0, 0, 0, 0, 1, 3'd5, 8'h33,   1, 3'b011, 0, 8'h22, 0, 0, 8'd4);
    tbl[18] = mk(0, 0, 0, 0, 1, 3'd6, 8'h44,   1, 3'b011, 0, 8'h22, 0, 0, 8'd4);
    tbl[19] = mk(0, 0, 0, 0, 0, 3'd0, 8'h00,   0, 3'b011, 1, 8'h44, 1, 0, 8'd5);
    tbl[20] = mk(0, 0, 0, 0, 0, 3'd0, 8'h00,   0, 3'b011, 0, 8'h44, 1, 0, 8'd5);
    tbl[21] = mk(0, 0, 0, 0, 0, 3'd0, 8'h00,   1, 3'b011, 0, 8'h44, 0, 0, 8'd5);

    drive(0, 0, 0, 0, 0, 3'd0, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    check_outs("reset", 1, 3'b000, 0, 8'h00, 0, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i].we, tbl[i].z, tbl[i].c, tbl[i].n, tbl[i].v, tbl[i].cond, tbl[i].tgt);
      #1;
      check_outs($sformatf("row%0d", i), tbl[i].rdy, tbl[i].flags, tbl[i].pl, tbl[i].pt,
                 tbl[i].fl, tbl[i].ce, tbl[i].cnt);
    end

    // Reset asserted in the middle of a flush cycle clears everything without waiting for a clock.
    @(negedge clk);
    drive(1, 1, 1, 1, 1, 3'd0, 8'hAA);
    #1;
    check("t1_accept_ready", int'(bf_if.br_ready), 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 3'd0, 8'h00);
    #1;
    check_outs("t1_pre", 0, 3'b111, 1, 8'hAA, 1, 0, 8'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("t1_rst", 1, 3'b000, 0, 8'h00, 0, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t1_post_flush", int'(bf_if.flush), 0);
    @(negedge clk);
    #1;
    check("t1_post_ready", int'(bf_if.br_ready), 1);

    // 260 always-taken branches issued at the minimum spacing of three cycles.
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 3'd0, 8'(i));
      #1;
      check("t6_ready", int'(bf_if.br_ready), 1);
      if (i == 254) check("t6_cnt_254", int'(bf_if.taken_cnt), 254);
      if (i == 255) check("t6_cnt_255", int'(bf_if.taken_cnt), 255);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 3'd0, 8'h00);
      #1;
      check("t6_pc_load", int'(bf_if.pc_load), 1);
      @(negedge clk);
    end
    #1;
    check("t6_cnt_sat", int'(bf_if.taken_cnt), 255);
    check("t6_last_target", int'(bf_if.pc_target), 259 % 256);
    check("t6_cond_err", int'(bf_if.cond_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
